// File: rtl/pipelined_cla_adder_pkg.sv
// Shared ALU definitions: default datapath geometry and the flag bundle
// consumed by the ALU result mux.
package pipelined_cla_adder_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_BLOCK = 8;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/pipelined_cla_adder_cla_block.sv
// One BLOCK-bit carry look-ahead slice. Every carry is a flat sum of products
// of generate/propagate terms, so no carry waits on its neighbour.
module cla_block
    import pipelined_cla_adder_pkg::*;
#(
    parameter int BLOCK = ALU_BLOCK
) (
    input  logic [BLOCK-1:0] A,
    input  logic [BLOCK-1:0] B,
    input  logic             CIN,
    output logic [BLOCK-1:0] S,
    output logic             COUT,
    output logic             CMSB
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             run;

    assign g = A & B;
    assign p = A | B;

    // NOTE: every variable written here gets a value before any branch or
    // loop reads it, so the block stays purely combinational (no latch).
    always_comb begin
        c    = '0;
        run  = 1'b0;
        c[0] = CIN;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i];
            run    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run & g[j]);
                run    = run & p[j];
            end
            c[i+1] = c[i+1] | (run & CIN);
        end
    end

    assign S    = A ^ B ^ c[BLOCK-1:0];
    assign COUT = c[BLOCK];
    assign CMSB = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract with NZCV flags: one look-ahead slice per stage,
// operands skewed in, result deskewed out, single global advance enable.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int BLOCK = ALU_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             V,
    output logic             N,
    output logic             Z
);

    localparam int STAGES = WIDTH / BLOCK;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    alu_flags_t       flags;

    // The whole pipe moves as one: a stalled output freezes every stage.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;
    assign b_eff    = B ^ {WIDTH{SUB}};
    assign cin_eff  = SUB | CIN;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * BLOCK;
        localparam int HI = LO + BLOCK - 1;

        logic [WIDTH-1:LO] a_src;
        logic [WIDTH-1:LO] b_src;
        logic [HI:0]       sum_d;
        logic [BLOCK-1:0]  s_sl;
        logic              cin_sl;
        logic              cout_sl;
        logic              vld_in;
        logic              z_in;
        logic              vld_q;
        logic              cout_q;
        logic              z_q;
        logic [HI:0]       sum_q;

        if (k == 0) begin : g_first
            assign a_src  = A;
            assign b_src  = b_eff;
            assign cin_sl = cin_eff;
            assign vld_in = in_valid;
            assign z_in   = 1'b1;
            assign sum_d  = s_sl;
        end else begin : g_next
            assign a_src  = g_stage[k-1].g_skew.a_q;
            assign b_src  = g_stage[k-1].g_skew.b_q;
            assign cin_sl = g_stage[k-1].cout_q;
            assign vld_in = g_stage[k-1].vld_q;
            assign z_in   = g_stage[k-1].z_q;
            assign sum_d  = {s_sl, g_stage[k-1].sum_q};
        end

        // NOTE: state registers use non-blocking assignments so every stage
        // samples its predecessor's pre-edge value and the pipe shifts cleanly.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                cout_q <= 1'b0;
                z_q    <= 1'b0;
                sum_q  <= '0;
            end else if (adv) begin
                vld_q  <= vld_in;
                cout_q <= cout_sl;
                z_q    <= z_in & (s_sl == '0);
                sum_q  <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:HI+1] a_q;
            logic [WIDTH-1:HI+1] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[WIDTH-1:HI+1];
                    b_q <= b_src[WIDTH-1:HI+1];
                end
            end
        end

        // Only the top slice's carry into the MSB feeds the overflow flag.
        if (k == STAGES - 1) begin : g_top
            logic cmsb_sl;
            logic v_q;

            cla_block #(.BLOCK(BLOCK)) u_cla (
                .A    (a_src[HI:LO]),
                .B    (b_src[HI:LO]),
                .CIN  (cin_sl),
                .S    (s_sl),
                .COUT (cout_sl),
                .CMSB (cmsb_sl)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= cout_sl ^ cmsb_sl;
                end
            end
        end else begin : g_mid
            logic unused_cmsb;

            cla_block #(.BLOCK(BLOCK)) u_cla (
                .A    (a_src[HI:LO]),
                .B    (b_src[HI:LO]),
                .CIN  (cin_sl),
                .S    (s_sl),
                .COUT (cout_sl),
                .CMSB (unused_cmsb)
            );
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign S         = g_stage[STAGES-1].sum_q;

    assign flags = '{
        n: g_stage[STAGES-1].sum_q[WIDTH-1],
        z: g_stage[STAGES-1].z_q,
        c: g_stage[STAGES-1].cout_q,
        v: g_stage[STAGES-1].g_top.v_q
    };

    assign N    = flags.n;
    assign Z    = flags.z;
    assign COUT = flags.c;
    assign V    = flags.v;

endmodule
